// File: rtl/jtag_frame_assembler.sv
// Double-buffered frame capture between the JTAG register bank and the SNN core.
// Beats of WORDS_PER_BEAT words arrive on rising edges of a synchronised NEXT
// strobe and fill a shadow frame; a completed frame is committed to oFRAME
// with a one-cycle oSTART as soon as the consumer is idle.
//
// Handshake: the host may deliver a beat whenever oREADY is high; a beat that
// arrives while oREADY is low (a finished frame is waiting for the consumer)
// is dropped and flagged on oOVERFLOW. oSTART is a single-cycle pulse with no
// acknowledge; the consumer signals it is done by dropping iSNN_BUSY.
module jtag_frame_assembler #(
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_BEAT = 14,
  parameter int FRAME_BITS     = 800,
  localparam int BEAT_W        = WORD_W * WORDS_PER_BEAT,
  localparam int BEATS         = (FRAME_BITS + BEAT_W - 1) / BEAT_W,
  localparam int CNT_W         = $clog2(BEATS + 1)
) (
  input  logic                  iCLK,
  input  logic                  iRESET,
  input  logic [BEAT_W-1:0]     iDATA,
  input  logic                  iNEXT,
  input  logic                  iLAST,
  input  logic                  iSNN_BUSY,
  input  logic                  iCLR_ERR,
  output logic [FRAME_BITS-1:0] oFRAME,
  output logic                  oSTART,
  output logic                  oREADY,
  output logic [CNT_W-1:0]      oBEATS,
  output logic                  oOVERFLOW,
  output logic                  oSHORT
);

  // Beat-aligned scratch width; anything above FRAME_BITS is thrown away.
  localparam int SH_W = BEATS * BEAT_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    sync1;
  logic                    sync2;
  logic                    sync3;
  logic                    beat_evt;
  logic [CNT_W-1:0]        rBEAT;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [FRAME_BITS-1:0]   shadow;
  logic [SH_W-1:0]         shadow_wr;
  logic                    short_pend;
  logic                    short_nxt;
  logic                    beat_ok;
  logic                    complete;
  logic                    commit;
  logic                    drop;

  // Bring the quasi-static NEXT level into the clock domain and keep one extra
  // delayed copy for rising-edge detection.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= iNEXT;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign beat_evt = sync2 & ~sync3;
  assign oREADY   = (state == FILL);

  // State register.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) state <= FILL;
    else        state <= state_nxt;
  end

  // Next state and per-cycle control: accept, complete, commit or drop a beat.
  always_comb begin
    state_nxt = state;
    beat_ok   = 1'b0;
    complete  = 1'b0;
    commit    = 1'b0;
    drop      = 1'b0;
    case (state)
      FILL: begin
        if (beat_evt) begin
          beat_ok  = 1'b1;
          complete = (rBEAT == LAST_IDX) || iLAST;
          if (complete) begin
            if (iSNN_BUSY) state_nxt = PEND;
            else           commit    = 1'b1;
          end
        end
      end
      PEND: begin
        drop = beat_evt;
        if (!iSNN_BUSY) begin
          commit    = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Shadow contents after this cycle's beat (if any) has been written.
  always_comb begin
    shadow_wr                   = '0;
    shadow_wr[FRAME_BITS-1:0]   = shadow;
    if (beat_ok) begin
      for (int b = 0; b < BEATS; b++) begin
        if (rBEAT == CNT_W'(b)) shadow_wr[b*BEAT_W +: BEAT_W] = iDATA;
      end
    end
  end

  assign cnt_nxt   = beat_ok ? rBEAT + CNT_W'(1) : rBEAT;
  // An early end only counts as short if it came before the natural last beat.
  assign short_nxt = complete ? (iLAST && (rBEAT != LAST_IDX)) : short_pend;

  generate
    if (SH_W > FRAME_BITS) begin : g_tail
      logic unused_tail;
      assign unused_tail = ^shadow_wr[SH_W-1:FRAME_BITS];
    end
  endgenerate

  // Shadow fill and commit into the frame seen by the network.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      oFRAME     <= '0;
      oBEATS     <= '0;
      oSTART     <= 1'b0;
      shadow     <= '0;
      rBEAT      <= '0;
      short_pend <= 1'b0;
    end else begin
      oSTART <= commit;
      if (commit) begin
        oFRAME     <= shadow_wr[FRAME_BITS-1:0];
        oBEATS     <= cnt_nxt;
        shadow     <= '0;
        rBEAT      <= '0;
        short_pend <= 1'b0;
      end else begin
        shadow <= shadow_wr[FRAME_BITS-1:0];
        rBEAT  <= cnt_nxt;
        if (complete) short_pend <= short_nxt;
      end
    end
  end

  // Sticky status; a new event in the same cycle as a clear takes priority.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      oOVERFLOW <= 1'b0;
      oSHORT    <= 1'b0;
    end else begin
      if (drop)          oOVERFLOW <= 1'b1;
      else if (iCLR_ERR) oOVERFLOW <= 1'b0;
      if (commit && short_nxt) oSHORT <= 1'b1;
      else if (iCLR_ERR)       oSHORT <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_frame_assembler.sv
// Bench for jtag_frame_assembler: default instance plus a narrow 8x4/40 instance.
module tb_jtag_frame_assembler;

  localparam int WW  = 32;
  localparam int WPB = 14;
  localparam int FB  = 800;
  localparam int BW  = WW * WPB;
  localparam int CW  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [BW-1:0] data = '0;
  logic          nxt = 1'b0;
  logic          last = 1'b0;
  logic          busy = 1'b0;
  logic          clr_err = 1'b0;
  logic [FB-1:0] frame;
  logic          start;
  logic          ready;
  logic [CW-1:0] beats;
  logic          overflow;
  logic          short_flag;

  logic [31:0]   s_data = '0;
  logic          s_nxt = 1'b0;
  logic          s_last = 1'b0;
  logic          s_busy = 1'b0;
  logic          s_clr = 1'b0;
  logic [39:0]   s_frame;
  logic          s_start;
  logic          s_ready;
  logic [1:0]    s_beats;
  logic          s_ovf;
  logic          s_short;

  jtag_frame_assembler dut (
    .iCLK(clk), .iRESET(rst), .iDATA(data), .iNEXT(nxt), .iLAST(last),
    .iSNN_BUSY(busy), .iCLR_ERR(clr_err), .oFRAME(frame), .oSTART(start),
    .oREADY(ready), .oBEATS(beats), .oOVERFLOW(overflow), .oSHORT(short_flag)
  );

  jtag_frame_assembler #(.WORD_W(8), .WORDS_PER_BEAT(4), .FRAME_BITS(40)) dut_small (
    .iCLK(clk), .iRESET(rst), .iDATA(s_data), .iNEXT(s_nxt), .iLAST(s_last),
    .iSNN_BUSY(s_busy), .iCLR_ERR(s_clr), .oFRAME(s_frame), .oSTART(s_start),
    .oREADY(s_ready), .oBEATS(s_beats), .oOVERFLOW(s_ovf), .oSHORT(s_short)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [FB-1:0] exp_q[$];
  logic [BW-1:0] sent[$];
  logic [FB-1:0] cap_frame[$];
  int            cap_beats[$];
  int            cap_short[$];
  int            cap_cyc[$];
  logic [FB-1:0] prev_frame;
  logic [FB-1:0] committed = '0;

  // Record every start pulse; the frame may only move on a start.
  always @(negedge clk) begin
    if (start) begin
      cap_frame.push_back(frame);
      cap_beats.push_back(int'(beats));
      cap_short.push_back(int'(short_flag));
      cap_cyc.push_back(cyc);
    end
    if (!rst && !start) begin
      n_checks++;
      if (frame !== prev_frame) begin
        n_fail++;
        $display("FAIL frame_stable act=%h exp=%h", frame, prev_frame);
      end
    end
    prev_frame = frame;
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic chk_frame(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic clear_err;
    clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
  endtask

  // Present data one cycle ahead, raise NEXT for 4+hold cycles, then hold it low.
  // With clr_evt the clear is asserted in exactly the cycle the beat is seen.
  task automatic send_beat(input logic [BW-1:0] d, input logic l, input bit clr_evt,
                           input int hold, output int rise);
    data = d;
    last = l;
    tick;
    nxt  = 1'b1;
    rise = cyc;
    tick;
    tick;
    if (clr_evt) clr_err = 1'b1;
    tick;
    clr_err = 1'b0;
    repeat (1 + hold) tick;
    nxt = 1'b0;
    repeat (3) tick;
  endtask

  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] d;
    for (int w = 0; w < WPB; w++) d[w*WW +: WW] = $urandom;
    return d;
  endfunction

  // Reference: bit i of the frame is bit (i mod BW) of received beat (i / BW),
  // or 0 if that beat never arrived.
  function automatic logic [FB-1:0] model_frame();
    logic [FB-1:0] f;
    f = '0;
    for (int i = 0; i < FB; i++) begin
      if ((i / BW) < sent.size()) f[i] = sent[i / BW][i % BW];
    end
    return f;
  endfunction

  task automatic check_commit(input string tag, input int exp_beats, input int exp_short,
                              input int exp_cyc);
    int waited;
    logic [FB-1:0] ef;
    waited = 0;
    while (cap_frame.size() == 0 && waited < 40) begin
      tick;
      waited++;
    end
    ef = exp_q.pop_front();
    chk({tag, "_start_seen"}, 64'(cap_frame.size() > 0), 64'd1);
    if (cap_frame.size() > 0) begin
      chk_frame({tag, "_frame"}, cap_frame.pop_front(), ef);
      chk({tag, "_beats"}, 64'(cap_beats.pop_front()), 64'(exp_beats));
      chk({tag, "_short"}, 64'(cap_short.pop_front()), 64'(exp_short));
      chk({tag, "_latency"}, 64'(cap_cyc.pop_front()), 64'(exp_cyc));
      chk({tag, "_single_start"}, 64'(cap_frame.size()), 64'd0);
    end
    committed = ef;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_frame({tag, "_frame"}, frame, '0);
    chk({tag, "_start"}, 64'(start), 64'd0);
    chk({tag, "_ready"}, 64'(ready), 64'd1);
    chk({tag, "_beats"}, 64'(beats), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
    chk({tag, "_short"}, 64'(short_flag), 64'd0);
  endtask

  typedef struct {
    int nbeats;
    bit use_last;
    int exp_beats;
    int exp_short;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ---------------- test sequence ----------------
  initial begin
    int rise;
    int drop_cyc;
    logic [BW-1:0] d;
    logic [31:0] sb0;
    logic [31:0] sb1;

    vecs[0] = '{nbeats: 2, use_last: 1'b0, exp_beats: 2, exp_short: 0};
    vecs[1] = '{nbeats: 1, use_last: 1'b1, exp_beats: 1, exp_short: 1};
    vecs[2] = '{nbeats: 2, use_last: 1'b1, exp_beats: 2, exp_short: 0};
    vecs[3] = '{nbeats: 1, use_last: 1'b1, exp_beats: 1, exp_short: 1};
    vecs[4] = '{nbeats: 2, use_last: 1'b0, exp_beats: 2, exp_short: 0};
    vecs[5] = '{nbeats: 2, use_last: 1'b1, exp_beats: 2, exp_short: 0};

    repeat (3) tick;
    chk_reset_vals("reset");
    rst = 1'b0;
    tick;

    // Counting pattern then 0xA0000000+i.
    sent.delete();
    for (int w = 0; w < WPB; w++) d[w*WW +: WW] = 32'(w);
    sent.push_back(d);
    send_beat(d, 1'b0, 1'b0, 0, rise);
    for (int w = 0; w < WPB; w++) d[w*WW +: WW] = 32'hA000_0000 + 32'(w);
    sent.push_back(d);
    send_beat(d, 1'b0, 1'b0, 0, rise);
    exp_q.push_back(model_frame());
    check_commit("basic", 2, 0, rise + 3);

    // Early end with an all-ones beat.
    sent.delete();
    d = '1;
    sent.push_back(d);
    send_beat(d, 1'b1, 1'b0, 0, rise);
    exp_q.push_back(model_frame());
    check_commit("early", 1, 1, rise + 3);
    chk("early_short_flag", 64'(short_flag), 64'd1);
    clear_err;
    chk("clr_short", 64'(short_flag), 64'd0);

    // Table of random frames.
    for (int v = 0; v < 6; v++) begin
      clear_err;
      sent.delete();
      for (int b = 0; b < vecs[v].nbeats; b++) begin
        d = rand_beat();
        sent.push_back(d);
        send_beat(d, vecs[v].use_last && (b == vecs[v].nbeats - 1), 1'b0, 0, rise);
      end
      exp_q.push_back(model_frame());
      check_commit($sformatf("vec%0d", v), vecs[v].exp_beats, vecs[v].exp_short, rise + 3);
      chk($sformatf("vec%0d_ready", v), 64'(ready), 64'd1);
    end

    // Consumer busy: frame waits, extra beats are dropped.
    clear_err;
    sent.delete();
    busy = 1'b1;
    for (int b = 0; b < 2; b++) begin
      d = rand_beat();
      sent.push_back(d);
      send_beat(d, 1'b0, 1'b0, 0, rise);
    end
    chk("busy_no_start", 64'(cap_frame.size()), 64'd0);
    chk("busy_ready", 64'(ready), 64'd0);
    repeat (20) tick;
    chk("busy_no_start_20", 64'(cap_frame.size()), 64'd0);
    send_beat(rand_beat(), 1'b0, 1'b0, 0, rise);
    chk("pend_overflow", 64'(overflow), 64'd1);
    chk_frame("pend_frame_hold", frame, committed);
    clear_err;
    chk("clr_overflow", 64'(overflow), 64'd0);
    send_beat(rand_beat(), 1'b0, 1'b1, 0, rise);
    chk("overflow_set_wins", 64'(overflow), 64'd1);
    chk("pend_ready", 64'(ready), 64'd0);
    busy = 1'b0;
    drop_cyc = cyc;
    exp_q.push_back(model_frame());
    check_commit("pend", 2, 0, drop_cyc + 1);
    chk("pend_ready_after", 64'(ready), 64'd1);
    chk("pend_overflow_sticky", 64'(overflow), 64'd1);

    // Reset in the middle of a frame, checked before any clock edge.
    send_beat(rand_beat(), 1'b0, 1'b0, 0, rise);
    rst = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    tick;
    tick;
    rst = 1'b0;
    tick;
    chk("reset_no_start", 64'(cap_frame.size()), 64'd0);
    sent.delete();
    for (int b = 0; b < 2; b++) begin
      d = rand_beat();
      sent.push_back(d);
      send_beat(d, 1'b0, 1'b0, 0, rise);
    end
    exp_q.push_back(model_frame());
    check_commit("after_reset", 2, 0, rise + 3);

    // Reset while a finished frame is pending.
    busy = 1'b1;
    for (int b = 0; b < 2; b++) send_beat(rand_beat(), 1'b0, 1'b0, 0, rise);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    busy = 1'b0;
    repeat (5) tick;
    chk("pend_reset_no_start", 64'(cap_frame.size()), 64'd0);
    chk("pend_reset_ready", 64'(ready), 64'd1);

    // NEXT held high for a long time counts as one beat.
    sent.delete();
    d = rand_beat();
    sent.push_back(d);
    send_beat(d, 1'b0, 1'b0, 20, rise);
    chk("held_single_beat", 64'(cap_frame.size()), 64'd0);
    d = rand_beat();
    sent.push_back(d);
    send_beat(d, 1'b0, 1'b0, 0, rise);
    exp_q.push_back(model_frame());
    check_commit("held", 2, 0, rise + 3);

    // Narrow instance: beat 1 contributes only its word 0.
    sb0 = $urandom;
    sb1 = $urandom;
    s_data = sb0;
    tick;
    s_nxt = 1'b1;
    repeat (4) tick;
    s_nxt = 1'b0;
    repeat (3) tick;
    chk("small_no_start_b0", 64'(s_start), 64'd0);
    s_data = sb1;
    tick;
    s_nxt = 1'b1;
    repeat (3) tick;
    chk("small_start", 64'(s_start), 64'd1);
    chk("small_frame", 64'(s_frame), 64'({sb1[7:0], sb0}));
    chk("small_beats", 64'(s_beats), 64'd2);
    chk("small_short", 64'(s_short), 64'd0);
    tick;
    chk("small_start_pulse", 64'(s_start), 64'd0);
    s_nxt = 1'b0;
    repeat (3) tick;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
